// File: rtl/disp_pkg.sv
// Shared types and constants for the multiplexed 7-segment display path.
package disp_pkg;

  // Default number of digits on the display module.
  localparam int NDIG_DEFAULT = 4;

  // Anode vector with every digit switched off (anodes are active-low).
  localparam logic [NDIG_DEFAULT-1:0] ANODE_OFF = '1;

  // One hexadecimal digit as handed to the segment decoder.
  typedef logic [3:0] nibble_t;

endpackage

// File: rtl/scan_tick_gen.sv
// Slot prescaler: counts DIV cycles per digit slot, flags the last cycle of
// each slot (tick) and the leading guard window (in_guard).
module scan_tick_gen #(
  parameter int DIV   = 50000,
  parameter int GUARD = 16
) (
  input  logic clk,
  input  logic rst,
  output logic tick,
  output logic in_guard
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
  localparam logic [CW-1:0] GUARD_C = CW'(GUARD);

  logic [CW-1:0] cnt;

  // Free-running slot counter, wraps at DIV-1 so every slot is exactly DIV cycles.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick     = (cnt == CNT_MAX);
  assign in_guard = (cnt < GUARD_C);

endmodule

// File: rtl/hex_scan_driver.sv
// Time-multiplexed scanner for a common-anode multi-digit 7-segment display.
// Steps one nibble per slot, commits newly loaded values only at frame
// boundaries, optionally blanks leading zeros and keeps anodes off during
// the guard interval at the start of every slot.
module hex_scan_driver
  import disp_pkg::*;
#(
  parameter int NDIG  = NDIG_DEFAULT,
  parameter int DIV   = 50000,
  parameter int GUARD = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [4*NDIG-1:0] value,
  input  logic              blank_lz,
  output nibble_t           digit_sel,
  output logic [NDIG-1:0]   an,
  output logic              pending
);

  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IW-1:0] IDX_MAX = IW'(NDIG - 1);

  logic              tick;
  logic              in_guard;
  logic [IW-1:0]     idx;
  logic [4*NDIG-1:0] shown;
  logic [4*NDIG-1:0] pend_val;
  logic              frame_end;
  logic [NDIG-1:0]   blank_vec;
  logic [NDIG-1:0]   onehot;
  logic [NDIG-1:0]   an_next;

  scan_tick_gen #(
    .DIV   (DIV),
    .GUARD (GUARD)
  ) u_tick (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .in_guard (in_guard)
  );

  assign frame_end = tick && (idx == IDX_MAX);

  // Digit index advances on every slot tick and wraps after the last digit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= '0;
    end else if (tick) begin
      idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
    end
  end

  // Pending/shown value pair: loads land in pend_val at any time, and are
  // copied into shown only at a frame boundary so a frame never tears.
  // A load coinciding with a commit re-arms pending for the next frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shown    <= '0;
      pend_val <= '0;
      pending  <= 1'b0;
    end else begin
      if (frame_end && pending) begin
        shown <= pend_val;
      end
      if (load) begin
        pend_val <= value;
        pending  <= 1'b1;
      end else if (frame_end) begin
        pending <= 1'b0;
      end
    end
  end

  // Digit i is blank when blanking is enabled and it and every more
  // significant nibble are zero; digit 0 always stays lit.
  assign blank_vec[0] = 1'b0;
  for (genvar i = 1; i < NDIG; i++) begin : g_blank
    assign blank_vec[i] = blank_lz && (shown[4*NDIG-1:4*i] == '0);
  end

  // Anode pattern for the current slot: all off in guard or when blank.
  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    onehot      = '0;
    onehot[idx] = 1'b1;
    an_next     = (in_guard || blank_vec[idx]) ? '1 : ~onehot;
  end

  // Registered outputs: reflect counter, index and shown value of the
  // previous cycle; digit_sel is driven even while the anodes are off.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an        <= '1;
      digit_sel <= '0;
    end else begin
      an        <= an_next;
      digit_sel <= shown[4*idx +: 4];
    end
  end

endmodule

// File: tb/tb_hex_scan_driver.sv
// Self-checking bench for hex_scan_driver (NDIG=4, DIV=8, GUARD=2).
// A cycle-count based reference model predicts every registered output.
module tb_hex_scan_driver;

  localparam int NDIG  = 4;
  localparam int DIV   = 8;
  localparam int GUARD = 2;
  localparam int FRAME = NDIG * DIV;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] value;
  logic        blank_lz;
  logic [3:0]  digit_sel;
  logic [3:0]  an;
  logic        pending;

  hex_scan_driver #(
    .NDIG  (NDIG),
    .DIV   (DIV),
    .GUARD (GUARD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .value     (value),
    .blank_lz  (blank_lz),
    .digit_sel (digit_sel),
    .an        (an),
    .pending   (pending)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: elapsed cycles since reset plus the value registers.
  int          cyc;
  logic [15:0] m_shown;
  logic [15:0] m_pend;
  logic        m_pending;

  // Timing measurement state.
  bit          measure;
  logic [3:0]  prev_an;
  int          last_fall [NDIG];
  int          last_any;
  int          low_cnt [NDIG];

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at model cycle %0d: observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    cyc       = 0;
    m_shown   = '0;
    m_pend    = '0;
    m_pending = 1'b0;
  endtask

  // One clock cycle: drive inputs, predict outputs from the spec rules,
  // advance the model, then compare after the edge.
  task automatic step(input logic ld, input logic [15:0] v, input logic blz);
    int         c;
    int         i;
    logic       blank;
    logic [3:0] e_an;
    logic [3:0] e_ds;
    load     = ld;
    value    = v;
    blank_lz = blz;
    c     = cyc % DIV;
    i     = (cyc / DIV) % NDIG;
    e_ds  = 4'((m_shown >> (4 * i)) & 16'h000F);
    blank = blz && (i != 0) && ((m_shown >> (4 * i)) == 16'h0000);
    e_an  = (c < GUARD || blank) ? 4'hF : ~(4'b0001 << i);
    if ((cyc % FRAME) == FRAME - 1 && m_pending) begin
      m_shown   = m_pend;
      m_pending = 1'b0;
    end
    if (ld) begin
      m_pend    = v;
      m_pending = 1'b1;
    end
    cyc++;
    @(posedge clk);
    #1;
    check("an", 16'(an), 16'(e_an));
    check("digit_sel", 16'(digit_sel), 16'(e_ds));
    check("pending", 16'(pending), 16'(m_pending));
    check("an_single_low", 16'($countones(~an) <= 1), 16'd1);
    if (measure) begin
      for (int d = 0; d < NDIG; d++) begin
        if (!an[d]) low_cnt[d]++;
        if (prev_an[d] && !an[d]) begin
          if (last_fall[d] >= 0) check("digit_period", 16'(cyc - last_fall[d]), 16'(FRAME));
          if (last_any >= 0) check("slot_period", 16'(cyc - last_any), 16'(DIV));
          last_fall[d] = cyc;
          last_any     = cyc;
        end
      end
    end
    prev_an = an;
    load    = 1'b0;
  endtask

  // Idle cycles (random value on the bus, no load) until the model reaches
  // the requested position within the frame; always fewer than FRAME steps.
  task automatic run_to(input int phase, input logic blz);
    while ((cyc % FRAME) != phase) step(1'b0, 16'($urandom), blz);
  endtask

  task automatic run_n(input int n, input logic blz);
    for (int k = 0; k < n; k++) step(1'b0, 16'($urandom), blz);
  endtask

  // Asynchronous reset asserted between clock edges; outputs must clear
  // before the next edge.
  task automatic mid_reset();
    #2;
    rst = 1'b1;
    #1;
    check("rst_an", 16'(an), 16'h000F);
    check("rst_digit_sel", 16'(digit_sel), 16'h0000);
    check("rst_pending", 16'(pending), 16'h0000);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    prev_an = an;
  endtask

  initial begin
    rst      = 1'b1;
    load     = 1'b0;
    value    = '0;
    blank_lz = 1'b0;
    measure  = 1'b0;
    model_reset();
    #12;
    check("por_an", 16'(an), 16'h000F);
    check("por_digit_sel", 16'(digit_sel), 16'h0000);
    check("por_pending", 16'(pending), 16'h0000);
    @(posedge clk);
    #1;
    rst     = 1'b0;
    prev_an = an;

    // Scan: load 1234 mid-frame, pending until boundary, then two frames.
    run_n(5, 1'b0);
    step(1'b1, 16'h1234, 1'b0);
    check("scan_pending_set", 16'(pending), 16'h0001);
    run_to(0, 1'b0);
    check("scan_committed", 16'(pending), 16'h0000);
    run_n(2 * FRAME, 1'b0);

    // Timing over three aligned frames.
    for (int d = 0; d < NDIG; d++) begin
      last_fall[d] = -1;
      low_cnt[d]   = 0;
    end
    last_any = -1;
    measure  = 1'b1;
    run_n(3 * FRAME, 1'b0);
    measure = 1'b0;
    for (int d = 0; d < NDIG; d++) check("low_cycles", 16'(low_cnt[d]), 16'(3 * (DIV - GUARD)));

    // Blanking: 0050 then 0000 with leading-zero blanking enabled.
    step(1'b1, 16'h0050, 1'b1);
    run_to(0, 1'b1);
    run_n(2 * FRAME, 1'b1);
    step(1'b1, 16'h0000, 1'b1);
    run_to(0, 1'b1);
    run_n(2 * FRAME, 1'b1);
    // Same zero value with blanking off: all four digits lit.
    run_n(FRAME, 1'b0);

    // Commit race: load on the boundary cycle itself.
    run_to(4, 1'b0);
    step(1'b1, 16'hAAAA, 1'b0);
    run_to(FRAME - 1, 1'b0);
    step(1'b1, 16'hBBBB, 1'b0);
    check("race_pending_kept", 16'(pending), 16'h0001);
    run_to(FRAME - 1, 1'b0);
    step(1'b0, 16'h5555, 1'b0);
    check("race_second_commit", 16'(pending), 16'h0000);
    run_n(FRAME, 1'b0);

    // Reset mid-frame discards a pending load.
    step(1'b1, 16'hCAFE, 1'b0);
    run_n(3, 1'b0);
    mid_reset();
    run_n(2 * FRAME, 1'b0);

    // Random traffic: sparse loads, random values and blanking.
    for (int k = 0; k < 600; k++) begin
      step(($urandom_range(0, 11) == 0), 16'($urandom >> ($urandom_range(0, 3) * 4)),
           1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
